// File: rtl/gpu_cmd_pkg.sv
// Shared types and constants for the tinygpu command front end.
// Header byte layout: {op[7:6], addr[5:0]}.
package gpu_cmd_pkg;

    localparam int REG_W       = 16;
    localparam int ADDR_W      = 6;
    localparam int HDR_OP_HI   = 7;
    localparam int HDR_OP_LO   = 6;
    localparam int HDR_ADDR_HI = 5;
    localparam int HDR_ADDR_LO = 0;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_WRITE   = 2'b01,
        OP_COMMIT  = 2'b10,
        OP_CLR_ERR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA_HI = 2'd1,
        DATA_LO = 2'd2,
        PEND    = 2'd3
    } state_e;

    function automatic op_e hdr_op(input logic [7:0] hdr);
        return op_e'(hdr[HDR_OP_HI:HDR_OP_LO]);
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[HDR_ADDR_HI:HDR_ADDR_LO];
    endfunction

endpackage

// File: rtl/gpu_cmd_watchdog.sv
// Inter-byte idle watchdog: counts enabled cycles while clear is low and
// pulses expire for exactly the cycle whose edge would reach TIMEOUT.
// The count restarts from zero after expiring.
module gpu_cmd_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          hit_s;

    // Next count and expiry decision; nothing moves while disabled.
    always_comb begin
        count_d = count_q;
        hit_s   = 1'b0;
        if (enable_i) begin
            if (clear_i) begin
                count_d = '0;
            end else if (count_q == CW'(TIMEOUT - 1)) begin
                hit_s   = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            count_d = count_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = hit_s;

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Byte-serial command front end: host writes land in a shadow bank, and a
// COMMIT copies the whole shadow bank into the active bank on the next
// vblank so the renderer never sees a half-updated set.
// Optional build macro GPU_CMD_SYNC_STROBE_EN: in_valid_i is treated as an
// asynchronous level, synchronized and rising-edge detected before use.
module gpu_cmd_scheduler
    import gpu_cmd_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             vblank_i,
    input  logic [5:0]       rd_addr_i,
    output logic [REG_W-1:0] rd_data_o,
    output logic             commit_pending_o,
    output logic [7:0]       frame_id_o,
    output logic             err_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        msb_q, msb_d;
    logic              err_q, err_d;
    logic [7:0]        frame_q, frame_d;

    logic [REG_W-1:0]  shadow_q [NUM_REGS];
    logic [REG_W-1:0]  active_q [NUM_REGS];

    logic              strobe_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              swap_s;
    logic              wd_clear_s;
    logic              expire_s;
    logic [REG_W-1:0]  rd_data_s;

`ifdef GPU_CMD_SYNC_STROBE_EN
    logic [2:0] sync_q;

    // Two-flop synchronizer plus one history flop for rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else if (ena_i) begin
            sync_q <= {sync_q[1:0], in_valid_i};
        end
    end

    assign strobe_s = sync_q[1] & ~sync_q[2];
`else
    assign strobe_s = in_valid_i;
`endif

    assign in_ready_s = ena_i && (state_q != PEND);
    assign accept_s   = strobe_s && in_ready_s;
    assign wd_clear_s = accept_s || !((state_q == DATA_HI) || (state_q == DATA_LO));

    gpu_cmd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (wd_clear_s),
        .enable_i (ena_i),
        .expire_o (expire_s)
    );

    // Command FSM next state and side effects; accept, expire and swap are
    // all already qualified by ena_i, so a low enable holds everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        msb_d   = msb_q;
        err_d   = err_q;
        frame_d = frame_q;
        wr_en_s = 1'b0;
        swap_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (hdr_op(in_data_i))
                        OP_NOP:     state_d = IDLE;
                        OP_WRITE: begin
                            addr_d  = hdr_addr(in_data_i);
                            state_d = DATA_HI;
                        end
                        OP_COMMIT:  state_d = PEND;
                        OP_CLR_ERR: err_d   = 1'b0;
                        default:    state_d = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            DATA_HI: begin
                if (accept_s) begin
                    msb_d   = in_data_i;
                    state_d = DATA_LO;
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DATA_HI;
                end
            end
            DATA_LO: begin
                if (accept_s) begin
                    // Out-of-range targets still consume both data bytes.
                    if ({1'b0, addr_q} < 7'(NUM_REGS)) begin
                        wr_en_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DATA_LO;
                end
            end
            PEND: begin
                if (vblank_i && ena_i) begin
                    swap_s  = 1'b1;
                    frame_d = frame_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    state_d = PEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and command control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            msb_q   <= 8'h00;
            err_q   <= 1'b0;
            frame_q <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            msb_q   <= msb_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    // Shadow bank: written at the edge that accepts the LSB byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (addr_q == 6'(i))) begin
                    shadow_q[i] <= {msb_q, in_data_i};
                end
            end
        end
    end

    // Active bank: whole-bank parallel copy on the swap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= '0;
            end
        end else if (swap_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Combinational read mux; addresses past the bank read as zero.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = rd_data_s | ({REG_W{rd_addr_i == 6'(i)}} & active_q[i]);
        end
    end

    assign in_ready_o       = in_ready_s;
    assign rd_data_o        = rd_data_s;
    assign commit_pending_o = (state_q == PEND);
    assign frame_id_o       = frame_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Scoreboard bench for gpu_cmd_scheduler: a command-level reference model
// predicts outputs for every cycle; a separate monitor pops and compares,
// and reads the whole active bank whenever a snapshot is requested.
`timescale 1ns/100ps
module tb_gpu_cmd_scheduler;

    localparam int NUM_REGS = 16;
    localparam int TIMEOUT  = 255;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ena      = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        vblank   = 1'b0;
    logic [5:0]  rd_addr  = 6'd0;
    logic        in_ready;
    logic [15:0] rd_data;
    logic        commit_pending;
    logic [7:0]  frame_id;
    logic        err;

    always #5 clk = ~clk;

    gpu_cmd_scheduler #(
        .NUM_REGS (NUM_REGS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ena_i            (ena),
        .in_data_i        (in_data),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .vblank_i         (vblank),
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data),
        .commit_pending_o (commit_pending),
        .frame_id_o       (frame_id),
        .err_o            (err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic              sweep;
        logic              ready;
        logic              cp;
        logic              er;
        logic [7:0]        frame;
        logic [63:0][15:0] act;
    } exp_t;

    exp_t expq[$];

    // Reference model, expressed as "bytes still owed" and a pending flag.
    int m_shadow[64];
    int m_active[64];
    bit m_pending;
    bit m_err;
    int m_frame;
    int m_need;
    int m_idle;
    int m_waddr;
    int m_msb;
    bit m_swapped;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_pending = 1'b0;
        m_err     = 1'b0;
        m_frame   = 0;
        m_need    = 0;
        m_idle    = 0;
        m_waddr   = 0;
        m_msb     = 0;
        m_swapped = 1'b0;
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_edge(input bit v, input logic [7:0] d, input bit vb, input bit en);
        bit acc;
        acc = v && en && !m_pending;
        if (!en) return;
        if (m_pending) begin
            if (vb) begin
                m_active  = m_shadow;
                m_frame   = (m_frame + 1) % 256;
                m_pending = 1'b0;
                m_swapped = 1'b1;
            end
        end else if (m_need == 0) begin
            if (acc) begin
                case (d >> 6)
                    1: begin m_need = 2; m_waddr = d % 64; m_idle = 0; end
                    2: m_pending = 1'b1;
                    3: m_err = 1'b0;
                    default: ;
                endcase
            end
        end else begin
            if (acc) begin
                m_idle = 0;
                if (m_need == 2) begin
                    m_msb  = d;
                    m_need = 1;
                end else begin
                    if (m_waddr < NUM_REGS) m_shadow[m_waddr] = m_msb * 256 + d;
                    else m_err = 1'b1;
                    m_need = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_need = 0;
                    m_idle = 0;
                    m_err  = 1'b1;
                end
            end
        end
    endtask

    // One bench cycle: drive inputs, queue the expectation for this cycle,
    // then advance the model across the coming edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit vb, input bit en,
                       input bit sw, input bit rst);
        exp_t e;
        @(posedge clk);
        #1;
        if (rst) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            rst_n = 1'b1;
        end
        in_valid = v;
        in_data  = d;
        vblank   = vb;
        ena      = en;
        e.sweep  = sw || m_swapped;
        e.ready  = en && !m_pending;
        e.cp     = m_pending;
        e.er     = m_err;
        e.frame  = 8'(m_frame);
        for (int i = 0; i < 64; i++) e.act[i] = 16'(m_active[i]);
        expq.push_back(e);
        m_swapped = 1'b0;
        if (!rst) model_edge(v, d, vb, en);
    endtask

    task automatic sendb(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic snap();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic pulse_vb();
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare every queued cycle; sweep the read port on request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("in_ready", 16'(in_ready), 16'(e.ready));
                chk("commit_pending", 16'(commit_pending), 16'(e.cp));
                chk("err", 16'(err), 16'(e.er));
                chk("frame_id", 16'(frame_id), 16'(e.frame));
                if (e.sweep) begin
                    for (int a = 0; a <= NUM_REGS; a++) begin
                        rd_addr = 6'(a);
                        #0.1;
                        chk($sformatf("rd_data@%0d", a), rd_data, e.act[a]);
                    end
                    rd_addr = 6'd63;
                    #0.1;
                    chk("rd_data@63", rd_data, e.act[63]);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        logic [7:0] b;
        model_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        snap();

        // Basic write, commit, delayed vblank swap.
        sendb(8'h41); sendb(8'h12); sendb(8'h34); sendb(8'h80);
        idle(8); snap();
        pulse_vb();
        idle(3);

        // Out-of-range write sets err, then CLR_ERR.
        sendb(8'h7F); sendb(8'hAA); sendb(8'hBB);
        idle(2);
        sendb(8'h80); pulse_vb(); idle(2);
        sendb(8'hC0); idle(2);

        // Timeout between bytes aborts and leaves shadow alone.
        sendb(8'h43); sendb(8'h55);
        idle(TIMEOUT + 4);
        sendb(8'h80); idle(3); pulse_vb(); idle(2);

        // COMMIT accepted together with vblank waits for the next pulse.
        cyc(1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5); pulse_vb(); idle(2);

        // Bytes offered during PEND are held off, then taken as a header.
        sendb(8'h80);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0);
        sendb(8'h42);
        sendb(8'h77); sendb(8'h88); sendb(8'h80); idle(2); pulse_vb(); idle(2);

        // vblank with ena low in PEND is ignored.
        sendb(8'h41); sendb(8'hCA); sendb(8'hFE); sendb(8'h80);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2); pulse_vb(); idle(2);

        // Reset between MSB and LSB of a write.
        sendb(8'h45); sendb(8'h99);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        snap();
        sendb(8'h80); pulse_vb(); idle(2);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 3))
                0:       b = {2'b00, 6'($urandom_range(0, 63))};
                1:       b = {2'b01, 6'($urandom_range(0, 19))};
                2:       b = {2'b10, 6'($urandom_range(0, 63))};
                default: b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                          : {2'b01, 6'($urandom_range(0, 15))};
            endcase
            cyc(1'($urandom_range(0, 1)), b, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0), 1'b0);
            if ($urandom_range(0, 799) == 0) idle(TIMEOUT + 2);
        end
        idle(2);

        @(negedge clk);
        #3;
        chk("queue_drained", 16'(expq.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
